conv_read_sequencer: RTL
========================

// Module: conv_read_sequencer
// PURPOSE
//  Top-level read scheduler for the shared Avalon read master: runs a layer as TileCount tiles.
//  Per tile: pulse Start_o, wait for the weight beat, then the feature lines, then engine completion.
//  Drives Halt_o from a credit count of free line-buffer slots so the read master never overruns the buffer.
//  Sits between the CSR/top FSM and the read master + IF/weight buffers.
// PARAMETERS
//  BUF_DEPTH    64  line-buffer capacity in lines (credits at reset); 2..256
//  HALT_MARGIN  3   Halt_o asserts when credits <= HALT_MARGIN (covers in-flight beats)
// PORTS
//  clk             in   1  system clock
//  rstn            in   1  asynchronous active-low reset
//  Go_i            in   1  1-cycle request: start layer (ignored unless IDLE)
//  TileCount_i     in   8  tiles in layer, sampled on Go_i; 0 treated as 1
//  Height_i        in   9  feature lines per tile, sampled on Go_i; 1..511
//  WgtOnly_i       in   1  sampled on Go_i; 1 = weight fetch only, no feature lines
//  Abort_i         in   1  synchronous abort, any state -> IDLE next cycle
//  Start_o         out  1  1-cycle start pulse to read master
//  Height_o        out  9  latched Height to read master
//  Share_o         out  1  ~latched WgtOnly; held stable for the whole layer
//  Halt_o          out  1  stall request to read master
//  WBValid_i       in   1  weight beat delivered
//  IBValid_i       in   1  feature line delivered (consumes 1 credit)
//  IBLast_i        in   1  final line of tile (qualified by IBValid_i)
//  LineFree_i      in   1  downstream freed one line slot (returns 1 credit)
//  EngineDone_i    in   1  compute engine finished current tile
//  Busy_o          out  1  state != IDLE
//  Done_o          out  1  1-cycle pulse: layer complete
//  TileIdx_o       out  8  index of tile in progress, 0-based
//  Credits_o       out  9  current free-slot count (debug)
// BEHAVIOUR
//  Reset: state IDLE; all pulses 0; Height_o/TileIdx_o 0; Share_o 1; Credits_o = BUF_DEPTH; Halt_o 0.
//  FSM: IDLE -Go_i-> START (latch cfg, TileIdx=0).
//   START: Start_o=1 for exactly 1 cycle -> WGT.
//   WGT: wait WBValid_i; WgtOnly -> DRAIN, else -> FEAT.
//   FEAT: wait IBValid_i&IBLast_i -> DRAIN. Stray WBValid_i ignored.
//   DRAIN: wait EngineDone_i; TileIdx==TileCount-1 -> DONE, else TileIdx++ -> START.
//   DONE: Done_o=1 one cycle -> IDLE. Go_i in same cycle is ignored.
//  Start->Start_o latency: Go_i at cycle n => Start_o at n+1.
//  Credits: 9-bit; -1 on IBValid_i, +1 on LineFree_i; both same cycle => unchanged.
//   Saturate at 0 and BUF_DEPTH (underflow/overflow is a protocol error, no wrap).
//   Credits persist across tiles and layers; only reset restores BUF_DEPTH.
//  Halt_o registered: Halt_o(n+1) = Busy & (Credits(n+1) <= HALT_MARGIN); 0 in IDLE/DONE.
//  Abort_i: priority over all transitions; no Done_o, TileIdx_o->0; credits kept.
//  EngineDone_i outside DRAIN is ignored (no latching).
//  Height_o/Share_o change only on Go_i acceptance; stable while Busy_o.
// TESTING
//  1) Go, TileCount=2, Height=4: WB, 4 IB (last on 4th), EngineDone each -> two Start_o pulses, TileIdx 0,1, Done_o once.
//  2) BUF_DEPTH=8, MARGIN=3, 5 IBValid w/o LineFree -> Credits 3, Halt_o=1 next cycle; 1 LineFree -> Halt_o=0.
//  3) IBValid_i & LineFree_i same cycle at Credits=4 -> Credits stays 4, Halt_o unchanged.
//  4) WgtOnly=1, TileCount=0 -> one Start_o, Share_o=0, WBValid then EngineDone -> Done_o; no FEAT entry.
//  5) Abort_i in FEAT of tile 1 -> IDLE next cycle, Busy_o=0, no Done_o; new Go_i restarts at TileIdx 0.
//  6) rstn low mid-FEAT -> outputs at reset values immediately; Credits_o=BUF_DEPTH.

Source files
------------

// File: rtl/conv_read_sequencer.sv
// Read scheduler for the shared read master. It runs a layer as a sequence of tiles:
// start pulse, weight beat, feature lines, then engine completion. It also tracks
// free line-buffer slots as credits and raises Halt_o when few remain.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for Go_i; configuration may be relatched
// START  | one-cycle Start_o pulse to the read master for the current tile
// WGT    | waiting for the weight beat
// FEAT   | receiving feature lines until the last line of the tile
// DRAIN  | waiting for the compute engine to finish the tile
// DONE   | one-cycle Done_o pulse, layer complete
module conv_read_sequencer #(
    parameter int BUF_DEPTH   = 64,
    parameter int HALT_MARGIN = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       Go_i,
    input  logic [7:0] TileCount_i,
    input  logic [8:0] Height_i,
    input  logic       WgtOnly_i,
    input  logic       Abort_i,
    output logic       Start_o,
    output logic [8:0] Height_o,
    output logic       Share_o,
    output logic       Halt_o,
    input  logic       WBValid_i,
    input  logic       IBValid_i,
    input  logic       IBLast_i,
    input  logic       LineFree_i,
    input  logic       EngineDone_i,
    output logic       Busy_o,
    output logic       Done_o,
    output logic [7:0] TileIdx_o,
    output logic [8:0] Credits_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WGT   = 3'd2,
        S_FEAT  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [8:0] CRED_MAX  = 9'(BUF_DEPTH);
    localparam logic [8:0] CRED_HALT = 9'(HALT_MARGIN);

    state_t     state_q, state_d;
    logic [7:0] last_idx_q, last_idx_d;
    logic [8:0] height_q, height_d;
    logic       share_q, share_d;
    logic [7:0] tile_idx_q, tile_idx_d;
    logic [8:0] credits_q, credits_d;
    logic       halt_q, halt_d;

    logic       go_accept;
    logic       last_tile;
    logic       busy_next;

    assign go_accept = (state_q == S_IDLE) && Go_i && !Abort_i;
    assign last_tile = (tile_idx_q == last_idx_q);

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            last_idx_q <= 8'd0;
            height_q   <= 9'd0;
            share_q    <= 1'b1;
            tile_idx_q <= 8'd0;
            credits_q  <= CRED_MAX;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_idx_q <= last_idx_d;
            height_q   <= height_d;
            share_q    <= share_d;
            tile_idx_q <= tile_idx_d;
            credits_q  <= credits_d;
            halt_q     <= halt_d;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Go_i) state_d = S_START;
            S_START: state_d = S_WGT;
            S_WGT:   if (WBValid_i) state_d = share_q ? S_FEAT : S_DRAIN;
            S_FEAT:  if (IBValid_i && IBLast_i) state_d = S_DRAIN;
            S_DRAIN: if (EngineDone_i) state_d = last_tile ? S_DONE : S_START;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (Abort_i) state_d = S_IDLE;
    end

    // Configuration latch and tile index; TileCount of 0 runs a single tile
    always_comb begin
        last_idx_d = last_idx_q;
        height_d   = height_q;
        share_d    = share_q;
        tile_idx_d = tile_idx_q;
        if (Abort_i) begin
            tile_idx_d = 8'd0;
        end else if (go_accept) begin
            last_idx_d = (TileCount_i == 8'd0) ? 8'd0 : TileCount_i - 8'd1;
            height_d   = Height_i;
            share_d    = !WgtOnly_i;
            tile_idx_d = 8'd0;
        end else if (state_q == S_DRAIN && EngineDone_i && !last_tile) begin
            tile_idx_d = tile_idx_q + 8'd1;
        end
    end

    // Credit counter saturates at both ends; halt is computed from next-cycle values so it is registered
    always_comb begin
        credits_d = credits_q;
        if (IBValid_i && !LineFree_i && credits_q != 9'd0) begin
            credits_d = credits_q - 9'd1;
        end else if (LineFree_i && !IBValid_i && credits_q < CRED_MAX) begin
            credits_d = credits_q + 9'd1;
        end
        busy_next = (state_d != S_IDLE) && (state_d != S_DONE);
        halt_d    = busy_next && (credits_d <= CRED_HALT);
    end

    // Moore outputs
    always_comb begin
        Start_o   = (state_q == S_START);
        Done_o    = (state_q == S_DONE);
        Busy_o    = (state_q != S_IDLE);
        Height_o  = height_q;
        Share_o   = share_q;
        Halt_o    = halt_q;
        TileIdx_o = tile_idx_q;
        Credits_o = credits_q;
    end

endmodule
